// File: rtl/capture_if.sv
// Capture record stream: one timestamped edge per transfer, valid/ready handshake.
// With CAPTURE_SCHED_DELTA_EN defined the record also carries cap_delta.
interface capture_if #(
  parameter int unsigned TIMER_WIDTH = 24,
  parameter int unsigned CHAN_WIDTH  = 2
);
  logic                   cap_valid;
  logic                   cap_ready;
  logic [CHAN_WIDTH-1:0]  cap_chan;
  logic                   cap_edge;
  logic [TIMER_WIDTH-1:0] cap_time;
`ifdef CAPTURE_SCHED_DELTA_EN
  logic [TIMER_WIDTH-1:0] cap_delta;
`endif

`ifdef CAPTURE_SCHED_DELTA_EN
  modport master (output cap_valid, cap_chan, cap_edge, cap_time, cap_delta, input cap_ready);
  modport slave  (input cap_valid, cap_chan, cap_edge, cap_time, cap_delta, output cap_ready);
`else
  modport master (output cap_valid, cap_chan, cap_edge, cap_time, input cap_ready);
  modport slave  (input cap_valid, cap_chan, cap_edge, cap_time, output cap_ready);
`endif
endinterface

// File: rtl/capture_scheduler.sv
// capture_scheduler: timestamps qualified rise/fall pulses per channel into a
// one-deep slot, then round-robin drains the slots into a registered
// valid/ready record stream. Lost events set a sticky per-channel ovf flag.
// Optional macro CAPTURE_SCHED_DELTA_EN adds cap_delta (time since the last
// delivered record of the same channel and edge polarity).
module capture_scheduler #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned TIMER_WIDTH = 24,
  parameter int unsigned CHAN_WIDTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [TIMER_WIDTH-1:0] timer,
  input  logic [CHANNELS-1:0]    rise,
  input  logic [CHANNELS-1:0]    fall,
  input  logic [CHANNELS-1:0]    rise_en,
  input  logic [CHANNELS-1:0]    fall_en,
  input  logic [CHANNELS-1:0]    ovf_clr,
  capture_if.master              cap,
  output logic [CHANNELS-1:0]    pending,
  output logic [CHANNELS-1:0]    ovf
);

  logic [CHANNELS-1:0]    ev_r, ev_f, ev;
  logic [CHANNELS-1:0]    unload, slot_wr, ovf_set, pend_nxt, ovf_nxt;
  logic                   slot_edge [CHANNELS];
  logic [TIMER_WIDTH-1:0] slot_time [CHANNELS];
  logic [CHAN_WIDTH-1:0]  ptr, ptr_nxt, gidx, sidx;
  logic                   found, load_ok, do_load;

  // Qualify events and compute slot/overflow next state
  always_comb begin
    ev_r     = {CHANNELS{ena}} & rise & rise_en;
    ev_f     = {CHANNELS{ena}} & fall & fall_en;
    ev       = ev_r | ev_f;
    load_ok  = ~cap.cap_valid | cap.cap_ready;
    do_load  = load_ok & found;
    unload   = do_load ? (CHANNELS'(1) << gidx) : '0;
    // A slot being drained this cycle can take a new event without loss
    slot_wr  = ev & (~pending | unload);
    ovf_set  = (ev_r & ev_f) | (ev & pending & ~unload);
    pend_nxt = slot_wr | (pending & ~unload);
    ovf_nxt  = ovf_set | (ovf & ~ovf_clr);
  end

  // Round-robin search starting at ptr
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    sidx  = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      sidx = CHAN_WIDTH'((32'(ptr) + k) % CHANNELS);
      if (!found && pending[sidx]) begin
        found = 1'b1;
        gidx  = sidx;
      end
    end
    ptr_nxt = (32'(gidx) == CHANNELS - 1) ? '0 : gidx + CHAN_WIDTH'(1);
  end

`ifdef CAPTURE_SCHED_DELTA_EN
  logic [TIMER_WIDTH-1:0] last_time [CHANNELS][2];
  logic [TIMER_WIDTH-1:0] prev_time;
  logic                   hs;

  // Previous timestamp for the granted slot, forwarding a same-cycle handshake
  always_comb begin
    hs        = cap.cap_valid & cap.cap_ready;
    prev_time = last_time[gidx][slot_edge[gidx]];
    if (hs && cap.cap_chan == gidx && cap.cap_edge == slot_edge[gidx])
      prev_time = cap.cap_time;
  end

  // Per-channel/per-edge history, updated on delivered records only
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        last_time[i][0] <= '0;
        last_time[i][1] <= '0;
      end
    end else if (hs) begin
      last_time[cap.cap_chan][cap.cap_edge] <= cap.cap_time;
    end
  end
`endif

  // Slots, status flags, arbitration pointer and output record
  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= '0;
      ovf           <= '0;
      ptr           <= '0;
      cap.cap_valid <= 1'b0;
      cap.cap_chan  <= '0;
      cap.cap_edge  <= 1'b0;
      cap.cap_time  <= '0;
`ifdef CAPTURE_SCHED_DELTA_EN
      cap.cap_delta <= '0;
`endif
      for (int i = 0; i < int'(CHANNELS); i++) begin
        slot_edge[i] <= 1'b0;
        slot_time[i] <= '0;
      end
    end else begin
      pending <= pend_nxt;
      ovf     <= ovf_nxt;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (slot_wr[i]) begin
          slot_edge[i] <= ev_r[i];
          slot_time[i] <= timer;
        end
      end
      if (do_load) begin
        cap.cap_valid <= 1'b1;
        cap.cap_chan  <= gidx;
        cap.cap_edge  <= slot_edge[gidx];
        cap.cap_time  <= slot_time[gidx];
`ifdef CAPTURE_SCHED_DELTA_EN
        cap.cap_delta <= slot_time[gidx] - prev_time;
`endif
        ptr           <= ptr_nxt;
      end else if (load_ok) begin
        cap.cap_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_capture_scheduler.sv
// Bench for capture_scheduler: table-driven single-cycle qualification vectors
// plus hand sequences for latency, arbitration, backpressure, overflow and reset.
module tb_capture_scheduler;

  logic        clk = 1'b0;
  logic        rst, ena;
  logic [23:0] timer;
  logic [3:0]  rise, fall, rise_en, fall_en, ovf_clr, pending, ovf;

  capture_if #(.TIMER_WIDTH(24), .CHAN_WIDTH(2)) cif ();

  capture_scheduler #(.CHANNELS(4), .TIMER_WIDTH(24), .CHAN_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .timer(timer),
    .rise(rise), .fall(fall), .rise_en(rise_en), .fall_en(fall_en),
    .ovf_clr(ovf_clr), .cap(cif), .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  chan;
    logic        edg;
    logic [23:0] tim;
    logic        chk_d;
    logic [23:0] dlt;
  } rec_t;

  typedef struct {
    logic       en;
    logic [3:0] r, f, ren, fen, clr, pend, ov;
    logic       has_rec;
    logic [1:0] ch;
    logic       edg;
  } vec_t;

  rec_t exp_q[$];
  rec_t mon_e;
  vec_t vt[7];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] c, input logic e, input logic [23:0] t,
                      input logic cd, input logic [23:0] d);
    rec_t r;
    r.chan = c; r.edg = e; r.tim = t; r.chk_d = cd; r.dlt = d;
    exp_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rise = '0; fall = '0; ovf_clr = '0;
  endtask

  // Scoreboard: a handshake completes on the coming edge; compare against the queue
  always @(negedge clk) begin
    if (!rst && cif.cap_valid && cif.cap_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got chan=%0d edge=%0d time=%h expected none",
                 cif.cap_chan, cif.cap_edge, cif.cap_time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("record", {5'd0, cif.cap_chan, cif.cap_edge, cif.cap_time},
            {5'd0, mon_e.chan, mon_e.edg, mon_e.tim});
`ifdef CAPTURE_SCHED_DELTA_EN
        if (mon_e.chk_d) chk("delta", {8'd0, cif.cap_delta}, {8'd0, mon_e.dlt});
`endif
      end
    end
  end

  initial begin
    // en, rise, fall, rise_en, fall_en, ovf_clr, exp pending, exp ovf, record?, chan, edge
    vt[0] = '{1'b1, 4'b0001, 4'b0000, 4'hF, 4'hF, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b1};
    vt[1] = '{1'b1, 4'b0000, 4'b1000, 4'hF, 4'hF, 4'b0000, 4'b1000, 4'b0000, 1'b1, 2'd3, 1'b0};
    vt[2] = '{1'b0, 4'b0010, 4'b0000, 4'hF, 4'hF, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vt[3] = '{1'b1, 4'b0001, 4'b0000, 4'hE, 4'hF, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vt[4] = '{1'b1, 4'b0000, 4'b0100, 4'hF, 4'hB, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vt[5] = '{1'b1, 4'b0100, 4'b0100, 4'hF, 4'hF, 4'b0000, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};
    vt[6] = '{1'b1, 4'b0100, 4'b0100, 4'hF, 4'hF, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};

    rst = 1'b1; ena = 1'b0; timer = '0; idle_in();
    rise_en = '0; fall_en = '0; cif.cap_ready = 1'b0;
    tick(); tick();
    chk("reset_valid", {31'd0, cif.cap_valid}, 32'd0);
    chk("reset_record", {5'd0, cif.cap_chan, cif.cap_edge, cif.cap_time}, 32'd0);
    chk("reset_pending", {28'd0, pending}, 32'd0);
    chk("reset_ovf", {28'd0, ovf}, 32'd0);
    rst = 1'b0; ena = 1'b1; rise_en = 4'hF; fall_en = 4'hF; cif.cap_ready = 1'b1;

    // Qualification table
    for (int i = 0; i < 7; i++) begin
      ena = vt[i].en; rise = vt[i].r; fall = vt[i].f;
      rise_en = vt[i].ren; fall_en = vt[i].fen; ovf_clr = vt[i].clr;
      timer = 24'(32'h010000 + i * 16);
      if (vt[i].has_rec) push(vt[i].ch, vt[i].edg, timer, 1'b0, '0);
      tick();
      idle_in(); ena = 1'b1; rise_en = 4'hF; fall_en = 4'hF;
      chk($sformatf("vec%0d_pending", i), {28'd0, pending}, {28'd0, vt[i].pend});
      chk($sformatf("vec%0d_ovf", i), {28'd0, ovf}, {28'd0, vt[i].ov});
      tick(); tick(); tick();
      chk($sformatf("vec%0d_drained", i), {31'd0, cif.cap_valid}, 32'd0);
      ovf_clr = 4'hF; tick(); ovf_clr = '0;
    end

    // Single event latency
    rise = 4'b0010; timer = 24'h000100; push(2'd1, 1'b1, timer, 1'b0, '0);
    tick(); idle_in();
    chk("lat_pending_t1", {27'd0, pending, cif.cap_valid}, {27'd0, 4'b0010, 1'b0});
    tick();
    chk("lat_out_t2", {1'b0, pending, cif.cap_valid, cif.cap_chan, cif.cap_edge, cif.cap_time},
        {1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 24'h000100});
    tick();
    chk("lat_done", {31'd0, cif.cap_valid}, 32'd0);

    // Simultaneous events, round-robin from ptr=0
    rst = 1'b1; tick(); rst = 1'b0;
    rise = 4'b1001; fall = 4'b0100; timer = 24'h000200;
    push(2'd0, 1'b1, timer, 1'b0, '0); push(2'd2, 1'b0, timer, 1'b0, '0);
    push(2'd3, 1'b1, timer, 1'b0, '0);
    tick(); idle_in();
    chk("rr_pending", {28'd0, pending}, 32'b1101);
    tick(); chk("rr_first", {25'd0, pending, cif.cap_valid, cif.cap_chan}, {25'd0, 4'b1100, 1'b1, 2'd0});
    tick(); chk("rr_second", {25'd0, pending, cif.cap_valid, cif.cap_chan}, {25'd0, 4'b1000, 1'b1, 2'd2});
    tick(); chk("rr_third", {25'd0, pending, cif.cap_valid, cif.cap_chan}, {25'd0, 4'b0000, 1'b1, 2'd3});
    tick();
    rise = 4'b1011; timer = 24'h000210;
    push(2'd0, 1'b1, timer, 1'b0, '0); push(2'd1, 1'b1, timer, 1'b0, '0);
    push(2'd3, 1'b1, timer, 1'b0, '0);
    tick(); idle_in(); tick(); tick(); tick(); tick();
    rise = 4'b0010; timer = 24'h000220; push(2'd1, 1'b1, timer, 1'b0, '0);
    tick(); idle_in(); tick(); tick();
    rise = 4'b1011; timer = 24'h000230;
    push(2'd3, 1'b1, timer, 1'b0, '0); push(2'd0, 1'b1, timer, 1'b0, '0);
    push(2'd1, 1'b1, timer, 1'b0, '0);
    tick(); idle_in(); tick(); tick(); tick(); tick();
    chk("rr_idle", {27'd0, pending, cif.cap_valid}, 32'd0);

    // Backpressure with overflow during hold
    cif.cap_ready = 1'b0;
    rise = 4'b0010; timer = 24'h000300; push(2'd1, 1'b1, timer, 1'b0, '0);
    tick(); idle_in(); tick();
    chk("bp_loaded", {4'd0, cif.cap_valid, cif.cap_chan, cif.cap_edge, cif.cap_time},
        {4'd0, 1'b1, 2'd1, 1'b1, 24'h000300});
    rise = 4'b0010; timer = 24'h000310; push(2'd1, 1'b1, timer, 1'b0, '0);
    tick(); idle_in();
    chk("bp_refill", {24'd0, pending, ovf}, {24'd0, 4'b0010, 4'b0000});
    rise = 4'b0010; timer = 24'h000320;
    tick(); idle_in();
    chk("bp_overflow", {24'd0, pending, ovf}, {24'd0, 4'b0010, 4'b0010});
    for (int j = 0; j < 5; j++) begin
      tick();
      chk($sformatf("bp_hold%0d", j), {4'd0, cif.cap_valid, cif.cap_chan, cif.cap_edge, cif.cap_time},
          {4'd0, 1'b1, 2'd1, 1'b1, 24'h000300});
    end
    cif.cap_ready = 1'b1;
    tick();
    chk("bp_kept_oldest", {7'd0, cif.cap_valid, cif.cap_time}, {7'd0, 1'b1, 24'h000310});
    tick();
    chk("bp_done", {27'd0, ovf, cif.cap_valid}, {27'd0, 4'b0010, 1'b0});
    ovf_clr = 4'b0010; tick(); idle_in();
    chk("bp_ovf_clr", {28'd0, ovf}, 32'd0);

    // Overflow flag set/clear priority
    rise = 4'b0100; fall = 4'b0100; timer = 24'h000400; push(2'd2, 1'b1, timer, 1'b0, '0);
    tick(); idle_in();
    chk("ov_both", {24'd0, pending, ovf}, {24'd0, 4'b0100, 4'b0100});
    tick(); tick();
    ovf_clr = 4'b0100; tick(); idle_in();
    chk("ov_clear", {28'd0, ovf}, 32'd0);
    rise = 4'b0100; fall = 4'b0100; timer = 24'h000410; push(2'd2, 1'b1, timer, 1'b0, '0);
    tick(); idle_in();
    rise = 4'b0100; fall = 4'b0100; ovf_clr = 4'b0100; timer = 24'h000420;
    push(2'd2, 1'b1, timer, 1'b0, '0);
    tick(); idle_in();
    chk("ov_set_beats_clr", {24'd0, pending, ovf}, {24'd0, 4'b0100, 4'b0100});
    ovf_clr = 4'b0001; tick(); idle_in();
    chk("ov_clr_unset", {28'd0, ovf}, 32'b0100);
    tick(); tick();
    ovf_clr = 4'b0100; tick(); idle_in();
    chk("ov_final_clear", {28'd0, ovf}, 32'd0);

    // Enables
    rise_en = 4'b1110; rise = 4'b0001; tick(); idle_in(); rise_en = 4'hF;
    chk("en_rise_off", {28'd0, pending}, 32'd0);
    ena = 1'b0; rise = 4'b0010; tick(); idle_in(); ena = 1'b1;
    chk("en_global_off", {28'd0, pending}, 32'd0);
    fall = 4'b1000; timer = 24'h000500; push(2'd3, 1'b0, timer, 1'b0, '0);
    tick(); idle_in();
    chk("en_fall", {28'd0, pending}, 32'b1000);
    tick();
    chk("en_fall_out", {29'd0, cif.cap_valid, cif.cap_edge, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
    tick(); tick();

    // Reset mid-transfer discards slots and the held record
    cif.cap_ready = 1'b0;
    rise = 4'b0001; timer = 24'h000600; tick();
    rise = 4'b0010; timer = 24'h000610; tick(); idle_in();
    chk("mrst_before", {27'd0, pending, cif.cap_valid}, {27'd0, 4'b0010, 1'b1});
    rst = 1'b1; cif.cap_ready = 1'b1; tick(); rst = 1'b0;
    chk("mrst_after", {3'd0, pending, cif.cap_valid, cif.cap_time}, 32'd0);
    tick(); tick(); tick();
    chk("mrst_quiet", {31'd0, cif.cap_valid}, 32'd0);

`ifdef CAPTURE_SCHED_DELTA_EN
    // Delta with wrap, per-edge history, and history cleared by reset
    rst = 1'b1; tick(); rst = 1'b0;
    rise = 4'b0001; timer = 24'hFFFFF0; push(2'd0, 1'b1, timer, 1'b1, 24'hFFFFF0);
    tick();
    rise = 4'b0001; timer = 24'h000010; push(2'd0, 1'b1, timer, 1'b1, 24'h000020);
    tick(); idle_in(); tick(); tick(); tick(); tick();
    fall = 4'b0001; timer = 24'h000030; push(2'd0, 1'b0, timer, 1'b1, 24'h000030);
    tick(); idle_in(); tick(); tick(); tick();
    rise = 4'b0001; timer = 24'h000040; tick(); idle_in();
    rst = 1'b1; tick(); rst = 1'b0;
    rise = 4'b0001; timer = 24'h000060; push(2'd0, 1'b1, timer, 1'b1, 24'h000060);
    tick(); idle_in(); tick(); tick(); tick();
`endif

    tick(); tick(); tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
